// File: rtl/ram_sp_fifo.sv
// ram_sp_fifo: FIFO over an external single-port RAM with a registered output stage.
// Define RAM_SP_FIFO_LEVEL_EN to enable the level output; otherwise level is tied to 0.
module ram_sp_fifo #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDRWIDTH:0]   level,
    output logic [ADDRWIDTH-1:0] ram_addr,
    output logic                 ram_we,
    output logic [DATAWIDTH-1:0] ram_wr_data,
    input  logic [DATAWIDTH-1:0] ram_rd_data
);
    localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};
    logic [ADDRWIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDRWIDTH:0]   r_cnt;
    logic                 r_pri;
    logic [DATAWIDTH-1:0] r_out_data;
    logic                 r_out_valid;
    logic                 w_full, w_empty, w_wr_req, w_fetch_req, w_do_wr, w_do_fetch;
    assign w_full      = r_cnt == DEPTH;
    assign w_empty     = r_cnt == '0;
    assign w_wr_req    = in_valid & !w_full;
    assign w_fetch_req = !w_empty & (!r_out_valid | out_ready);
    // r_pri high means the fetch side wins a simultaneous request
    assign w_do_wr     = w_wr_req & (!w_fetch_req | !r_pri);
    assign w_do_fetch  = w_fetch_req & (!w_wr_req | r_pri);
    assign in_ready    = !w_full & !(w_fetch_req & r_pri);
    assign ram_we      = w_do_wr & !reset;
    assign ram_addr    = w_do_wr ? r_wr_ptr : r_rd_ptr;
    assign ram_wr_data = in_data;
    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cnt       <= '0;
            r_pri       <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + ADDRWIDTH'(w_do_wr);
            r_rd_ptr <= r_rd_ptr + ADDRWIDTH'(w_do_fetch);
            r_cnt    <= r_cnt + (ADDRWIDTH+1)'(w_do_wr) - (ADDRWIDTH+1)'(w_do_fetch);
            r_pri    <= w_do_wr | (r_pri & !w_do_fetch);
            if (w_do_fetch) begin
                r_out_data  <= ram_rd_data;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`ifdef RAM_SP_FIFO_LEVEL_EN
    assign level = r_cnt + (ADDRWIDTH+1)'(r_out_valid);
`else
    assign level = '0;
`endif
endmodule

// File: tb/tb_ram_sp_fifo.sv
// tb_ram_sp_fifo: directed checks of ram_sp_fifo (ADDRWIDTH=2) against a behavioural RAM.
module tb_ram_sp_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] level;
    logic [1:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;
    logic [7:0] mem [0:3];
    int checks = 0;
    int failures = 0;

    ram_sp_fifo #(.DATAWIDTH(8), .ADDRWIDTH(2)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;
    assign ram_rd_data = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wr_data;

    function automatic logic [2:0] elv(input logic [2:0] v);
`ifdef RAM_SP_FIFO_LEVEL_EN
        return v;
`else
        return 3'd0;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_valid = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        out_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got %h want 00", out_data); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
        tick();
        in_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_first_word;
        do_reset();
        in_valid = 1'b1;
        in_data = 8'hA5;
        out_ready = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL first_we got %b want 1", ram_we); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_early_valid got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin failures++; $display("FAIL first_data got %h want a5", out_data); end
        checks++; if (level !== elv(3'd1)) begin failures++; $display("FAIL first_level got %0d want %0d", level, elv(3'd1)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL first_popped got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL first_level_empty got %0d want 0", level); end
    endtask

    task automatic test_full;
        int k = 0;
        int n = 0;
        logic acc, pop;
        logic [7:0] pd;
        do_reset();
        in_valid = 1'b1;
        in_data = 8'd0;
        for (int i = 0; i < 12; i++) begin
            #1;
            acc = in_ready;
            tick();
            if (acc) begin k++; in_data = 8'(k); end
        end
        #1;
        checks++; if (k !== 5) begin failures++; $display("FAIL full_accepts got %0d want 5", k); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got %b want 0", in_ready); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL full_ram_we got %b want 0", ram_we); end
        checks++; if (level !== elv(3'd5)) begin failures++; $display("FAIL full_level got %0d want %0d", level, elv(3'd5)); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            pop = out_valid;
            pd = out_data;
            tick();
            if (pop) begin
                checks++; if (pd !== 8'(n)) begin failures++; $display("FAIL full_pop%0d got %h want %h", n, pd, 8'(n)); end
                n++;
            end
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL full_pop_count got %0d want 5", n); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drained_valid got %b want 0", out_valid); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL drained_we got %b want 0", ram_we); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL drained_level got %0d want 0", level); end
    endtask

    task automatic test_back_to_back;
        int k = 0;
        int n = 0;
        logic acc, pop;
        logic [7:0] pd;
        do_reset();
        in_valid = 1'b1;
        in_data = 8'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            acc = in_ready;
            tick();
            if (acc) begin k++; in_data = 8'(k); end
        end
        checks++; if (k !== 3) begin failures++; $display("FAIL b2b_setup_accepts got %0d want 3", k); end
        checks++; if (level !== elv(3'd3)) begin failures++; $display("FAIL b2b_level got %0d want %0d", level, elv(3'd3)); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (ram_we !== i[0]) begin failures++; $display("FAIL b2b_we%0d got %b want %b", i, ram_we, i[0]); end
            acc = in_ready;
            pop = out_valid;
            pd = out_data;
            tick();
            if (acc) begin k++; in_data = 8'(k); end
            if (pop) begin
                checks++; if (pd !== 8'(n)) begin failures++; $display("FAIL b2b_pop%0d got %h want %h", n, pd, 8'(n)); end
                n++;
            end
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL b2b_pop_count got %0d want 5", n); end
    endtask

    task automatic test_wrap;
        int k = 0;
        int n = 0;
        logic acc, pop;
        logic [7:0] pd;
        do_reset();
        in_valid = 1'b1;
        in_data = 8'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && n < 20; i++) begin
            #1;
            acc = in_valid & in_ready;
            pop = out_valid;
            pd = out_data;
            tick();
            if (acc) begin
                k++;
                if (k == 20) in_valid = 1'b0;
                else in_data = 8'(k);
            end
            if (pop) begin
                checks++; if (pd !== 8'(n)) begin failures++; $display("FAIL wrap_pop%0d got %h want %h", n, pd, 8'(n)); end
                n++;
            end
        end
        checks++; if (n !== 20) begin failures++; $display("FAIL wrap_count got %0d want 20", n); end
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_drained got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        in_valid = 1'b1;
        in_data = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            in_data = in_data + 8'(in_ready);
        end
        in_valid = 1'b0;
        #1;
        checks++; if (level !== elv(3'd3)) begin failures++; $display("FAIL mid_level got %0d want %0d", level, elv(3'd3)); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid got %b want 1", out_valid); end
        in_valid = 1'b1;
        in_data = 8'h11;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL mid_rst_level got %0d want 0", level); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL mid_rst_we got %b want 0", ram_we); end
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL post_rst_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 8'h11) begin failures++; $display("FAIL post_rst_data got %h want 11", out_data); end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_full();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule

// File: doc/ram_sp_fifo.md
RAM_SP_FIFO -- requirements
Module: ram_sp_fifo

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, meaning word width in bits.
REQ-002 SHALL have parameter ADDRWIDTH, default 9, meaning RAM address width; RAM depth is 2^ADDRWIDTH words.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  DATAWIDTH  push data.
REQ-006 SHALL have port in_valid  input  1  push request.
REQ-007 SHALL have port in_ready  output  1  push accepted when in_valid & in_ready at a rising edge.
REQ-008 SHALL have port out_data  output  DATAWIDTH  registered pop data.
REQ-009 SHALL have port out_valid  output  1  registered; out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  pop completes when out_valid & out_ready at a rising edge.
REQ-011 SHALL have port level  output  ADDRWIDTH+1  word count in RAM plus output register.
REQ-012 SHALL have port ram_addr  output  ADDRWIDTH  address to the external single-port RAM.
REQ-013 SHALL have port ram_we  output  1  RAM write enable.
REQ-014 SHALL have port ram_wr_data  output  DATAWIDTH  RAM write data (equals in_data).
REQ-015 SHALL have port ram_rd_data  input  DATAWIDTH  RAM read data, combinational from ram_addr.

Function
REQ-016 SHALL keep wr_ptr and rd_ptr (ADDRWIDTH bits, wrap modulo 2^ADDRWIDTH) and ram_cnt (ADDRWIDTH+1 bits); full = (ram_cnt == 2^ADDRWIDTH), empty = (ram_cnt == 0).
REQ-017 SHALL perform at most one RAM operation per cycle: write (ram_we=1, ram_addr=wr_ptr) or fetch (ram_we=0, ram_addr=rd_ptr); idle drives ram_addr=rd_ptr, ram_we=0.
REQ-018 SHALL define wr_req = in_valid & !full and fetch_req = !empty & (!out_valid | out_ready).
REQ-019 SHALL hold a priority bit pri (W or R): both requests -> pri chooses; one request -> it wins; after a write pri=R, after a fetch pri=W, otherwise unchanged.
REQ-020 SHALL drive in_ready = !full & !(fetch_req & pri==R); in_ready never depends on in_valid.
REQ-021 SHALL on fetch load out_data <= ram_rd_data, out_valid <= 1, rd_ptr++; on pop without fetch clear out_valid; out_data unchanged while out_valid & !out_ready.
REQ-022 SHALL on write increment wr_ptr; ram_cnt += write - fetch.
REQ-023 SHALL give first-word latency of 2 cycles: push accepted at edge N into empty FIFO -> out_valid=1 after edge N+1.
REQ-024 SHALL sustain one pop per cycle when no push contends, and alternate write/fetch under simultaneous demand.
REQ-025 SHALL deassert in_ready while full; no write to RAM occurs when full.
REQ-026 SHALL hold out_valid=0 and never fetch when empty and output register drained.
REQ-027 SHALL compute level = ram_cnt + out_valid; maximum 2^ADDRWIDTH+1, never wraps.

Reset
REQ-028 SHALL on reset assertion immediately force wr_ptr=0, rd_ptr=0, ram_cnt=0, pri=W, out_valid=0, out_data=0, level=0, ram_we=0, in_ready=1 (for ADDRWIDTH>=1).
REQ-029 SHALL discard all contents on reset mid-operation; RAM contents are not cleared.

Configuration
REQ-030 SHALL, with macro RAM_SP_FIFO_LEVEL_EN defined, compute level per REQ-027 with its counter logic.
REQ-031 SHALL, without RAM_SP_FIFO_LEVEL_EN, tie level to 0 and omit its logic; all other behaviour identical.

Verification
REQ-032 SHALL cover: push 0xA5 to empty FIFO at edge 1, out_ready=1 -> out_valid=1, out_data=0xA5 after edge 2, level 1 -> 0 after pop.
REQ-033 SHALL cover: ADDRWIDTH=2, push 0..5 with out_ready=0 -> in_ready=0 after 5 accepts (4 RAM + 1 out reg), level=5, pops return 0..4 in order.
REQ-034 SHALL cover: in_valid=1 and out_ready=1 continuously with 3 words stored -> ram_we alternates 1,0,1,0; data order preserved.
REQ-035 SHALL cover: wr_ptr wrap, 20 push/pop pairs through ADDRWIDTH=2 -> outputs equal inputs 0..19.
REQ-036 SHALL cover: reset asserted with level=3 mid-transfer -> out_valid=0, level=0 same cycle; next push 0x11 emerges first.
REQ-037 SHALL cover: build without RAM_SP_FIFO_LEVEL_EN -> level stays 0; REQ-032 data results unchanged.
